// File: rtl/plb_dac_stream.sv
// Multi-channel DAC sample engine: frame FIFO, programmable frame pacing and channel interleaving.
// Define PLB_DAC_STREAM_PATTERN_EN to send a ramp test pattern on underrun instead of repeating the last frame.
module plb_dac_stream #(
    parameter int DAC_WIDTH = 10,
    parameter int NUM_CH    = 2,
    parameter int FIFO_AW   = 4,
    parameter int DIV_WIDTH = 16,
    localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        SPLB_Clk,
    input  logic                        SPLB_Rst,
    input  logic                        wr_en,
    input  logic [DAC_WIDTH*NUM_CH-1:0] wr_data,
    output logic                        wr_full,
    output logic [FIFO_AW:0]            fifo_level,
    input  logic                        enable,
    input  logic                        flush,
    input  logic [DIV_WIDTH-1:0]        rate_div,
    input  logic                        fmt_offset,
    input  logic                        clr_status,
    output logic                        underrun,
    output logic                        overflow,
    output logic [DAC_WIDTH-1:0]        S_Data,
    output logic [CHW-1:0]              S_ChSel,
    output logic                        S_DCLKIO,
    output logic                        S_PWRDN
);
    localparam int FW    = DAC_WIDTH * NUM_CH;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int SW    = $clog2(NUM_CH + 1);
    localparam logic [FIFO_AW:0]     DEPTH_L = (FIFO_AW + 1)'(DEPTH);
    localparam logic [SW-1:0]        NCH_L   = SW'(NUM_CH);
    localparam logic [DIV_WIDTH-1:0] MIN_PM1 = DIV_WIDTH'(NUM_CH - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t               state_q;
    logic [DIV_WIDTH-1:0] cnt_q, per_q, per_lim_s;
    logic [SW-1:0]        slot_q;
    logic [FW-1:0]        frame_q, next_frame_s;
    logic [DAC_WIDTH-1:0] slot_data_s;
    logic [FW-1:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     level_q, level_d;
    logic                 full_q, empty_s, push_s, pop_s, tick_s;
    logic                 underrun_q, overflow_q;
    logic [DAC_WIDTH-1:0] s_data_q;
    logic [CHW-1:0]       s_chsel_q;
    logic                 s_dclk_q, s_pwrdn_q;
`ifdef PLB_DAC_STREAM_PATTERN_EN
    logic [DAC_WIDTH-1:0] ramp_q;
`endif

    function automatic logic [DAC_WIDTH-1:0] fmt_f(input logic [DAC_WIDTH-1:0] s, input logic inv);
        return s ^ (DAC_WIDTH'(inv) << (DAC_WIDTH - 1));
    endfunction

    assign wr_full    = full_q;
    assign fifo_level = level_q;
    assign underrun   = underrun_q;
    assign overflow   = overflow_q;
    assign S_Data     = s_data_q;
    assign S_ChSel    = s_chsel_q;
    assign S_DCLKIO   = s_dclk_q;
    assign S_PWRDN    = s_pwrdn_q;

    assign empty_s   = (level_q == '0);
    assign per_lim_s = (rate_div < MIN_PM1) ? MIN_PM1 : rate_div;
    // A tick is suppressed on the cycle enable drops so no frame is popped on the way to idle.
    assign tick_s    = (state_q == ST_RUN) && enable && (cnt_q == per_q);

    // FIFO push/pop qualification and next fill level.
    always_comb begin
        push_s  = wr_en && !full_q && !flush;
        pop_s   = tick_s && !empty_s;
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else if (push_s && !pop_s) begin
            level_d = level_q + 1'b1;
        end else if (!push_s && pop_s) begin
            level_d = level_q - 1'b1;
        end else begin
            level_d = level_q;
        end
    end

    // Frame to present on a tick: FIFO head, or the underrun substitute.
    always_comb begin
        next_frame_s = frame_q;
        if (!empty_s) begin
            next_frame_s = mem_q[rd_ptr_q];
        end else begin
`ifdef PLB_DAC_STREAM_PATTERN_EN
            for (int k = 0; k < NUM_CH; k++) begin
                next_frame_s[k*DAC_WIDTH +: DAC_WIDTH] = ramp_q + DAC_WIDTH'(k);
            end
`else
            next_frame_s = frame_q;
`endif
        end
    end

    // Sample of the current frame for the channel slot being serialised.
    always_comb begin
        slot_data_s = frame_q[DAC_WIDTH-1:0];
        if (slot_q < NCH_L) begin
            slot_data_s = frame_q[int'(slot_q)*DAC_WIDTH +: DAC_WIDTH];
        end else begin
            slot_data_s = frame_q[DAC_WIDTH-1:0];
        end
    end

    // FIFO storage array.
    always_ff @(posedge SPLB_Clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers, level, full flag and sticky status flags.
    always_ff @(posedge SPLB_Clk) begin
        if (SPLB_Rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q    <= level_d;
            full_q     <= (level_d == DEPTH_L);
            underrun_q <= (tick_s && empty_s) ? 1'b1 : (clr_status ? 1'b0 : underrun_q);
            overflow_q <= (wr_en && full_q && !flush) ? 1'b1 : (clr_status ? 1'b0 : overflow_q);
        end
    end

    // Run/idle control, rate divider and per-channel output serialiser.
    always_ff @(posedge SPLB_Clk) begin
        if (SPLB_Rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            per_q     <= '0;
            slot_q    <= NCH_L;
            frame_q   <= '0;
            s_data_q  <= '0;
            s_chsel_q <= '0;
            s_dclk_q  <= 1'b0;
            s_pwrdn_q <= 1'b1;
`ifdef PLB_DAC_STREAM_PATTERN_EN
            ramp_q    <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q     <= '0;
                    per_q     <= per_lim_s;
                    slot_q    <= NCH_L;
                    s_data_q  <= '0;
                    s_chsel_q <= '0;
                    s_dclk_q  <= 1'b0;
                    if (enable) begin
                        state_q   <= ST_RUN;
                        s_pwrdn_q <= 1'b0;
`ifdef PLB_DAC_STREAM_PATTERN_EN
                        ramp_q    <= '0;
`endif
                    end else begin
                        state_q   <= ST_IDLE;
                        s_pwrdn_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        slot_q    <= NCH_L;
                        s_data_q  <= '0;
                        s_chsel_q <= '0;
                        s_dclk_q  <= 1'b0;
                        s_pwrdn_q <= 1'b1;
                    end else if (tick_s) begin
                        cnt_q     <= '0;
                        per_q     <= per_lim_s;
                        frame_q   <= next_frame_s;
                        s_data_q  <= fmt_f(next_frame_s[DAC_WIDTH-1:0], fmt_offset);
                        s_chsel_q <= '0;
                        s_dclk_q  <= 1'b1;
                        slot_q    <= SW'(1);
`ifdef PLB_DAC_STREAM_PATTERN_EN
                        if (empty_s) ramp_q <= ramp_q + 1'b1;
`endif
                    end else begin
                        cnt_q    <= cnt_q + 1'b1;
                        s_dclk_q <= 1'b0;
                        if (slot_q < NCH_L) begin
                            s_data_q  <= fmt_f(slot_data_s, fmt_offset);
                            s_chsel_q <= CHW'(slot_q);
                            slot_q    <= slot_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    s_pwrdn_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_plb_dac_stream.sv
// Randomised scoreboard bench for plb_dac_stream against a queue-based reference model.
module tb_plb_dac_stream;
    localparam int DW    = 10;
    localparam int NCH   = 2;
    localparam int AW    = 4;
    localparam int DIVW  = 16;
    localparam int FW    = DW * NCH;
    localparam int DEPTH = 2 ** AW;
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;

    logic            SPLB_Clk;
    logic            rst, wr_en, enable, flush, fmt_offset, clr_status;
    logic [FW-1:0]   wr_data;
    logic [DIVW-1:0] rate_div;
    logic            wr_full, underrun, overflow, S_DCLKIO, S_PWRDN;
    logic [AW:0]     fifo_level;
    logic [DW-1:0]   S_Data;
    logic [CHW-1:0]  S_ChSel;

    plb_dac_stream #(.DAC_WIDTH(DW), .NUM_CH(NCH), .FIFO_AW(AW), .DIV_WIDTH(DIVW)) dut (
        .SPLB_Clk(SPLB_Clk), .SPLB_Rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full), .fifo_level(fifo_level), .enable(enable), .flush(flush),
        .rate_div(rate_div), .fmt_offset(fmt_offset), .clr_status(clr_status),
        .underrun(underrun), .overflow(overflow), .S_Data(S_Data), .S_ChSel(S_ChSel),
        .S_DCLKIO(S_DCLKIO), .S_PWRDN(S_PWRDN)
    );

    initial begin
        SPLB_Clk = 1'b0;
        forever #5 SPLB_Clk = ~SPLB_Clk;
    end

    typedef struct {
        logic [DW-1:0]  data;
        logic [CHW-1:0] chsel;
        logic           dclk, pwrdn, full, under, over;
        logic [AW:0]    level;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model state
    bit            m_run;
    logic [FW-1:0] m_fifo[$];
    logic [FW-1:0] m_frame;
    int            m_slot, m_ramp;
    longint        m_cyc = 0, m_tick_at = 0;
    exp_t          m_out;

    function automatic logic [DW-1:0] ch_of(input logic [FW-1:0] f, input int k);
        return DW'(f >> (k * DW));
    endfunction

    function automatic logic [DW-1:0] fmt_m(input logic [DW-1:0] v, input logic inv);
        return inv ? (v ^ DW'(1 << (DW - 1))) : v;
    endfunction

    function automatic longint period(input logic [DIVW-1:0] rd);
        return ((int'(rd) > NCH - 1) ? longint'(rd) : longint'(NCH - 1)) + 1;
    endfunction

    // Predict the registered outputs after the coming clock edge from the current inputs.
    task automatic model_step();
        exp_t          e;
        logic [FW-1:0] popped, nf;
        bit            was_empty, was_full, tick;
        e      = m_out;
        popped = '0;
        nf     = '0;
        if (rst) begin
            m_run = 1'b0; m_fifo.delete(); m_frame = '0; m_ramp = 0; m_slot = NCH;
            e.data = '0; e.chsel = '0; e.dclk = 1'b0; e.pwrdn = 1'b1;
            e.full = 1'b0; e.level = '0; e.under = 1'b0; e.over = 1'b0;
        end else begin
            was_empty = (m_fifo.size() == 0);
            was_full  = (m_fifo.size() == DEPTH);
            tick      = m_run && enable && (m_cyc == m_tick_at);
            if (tick && !was_empty) popped = m_fifo.pop_front();
            if (flush) m_fifo.delete();
            else if (wr_en && !was_full) m_fifo.push_back(wr_data);
            e.under = (tick && was_empty) ? 1'b1 : (clr_status ? 1'b0 : e.under);
            e.over  = (wr_en && was_full && !flush) ? 1'b1 : (clr_status ? 1'b0 : e.over);
            e.level = (AW + 1)'(m_fifo.size());
            e.full  = (m_fifo.size() == DEPTH);
            e.dclk  = 1'b0;
            if (!m_run || !enable) begin
                e.data = '0; e.chsel = '0; m_slot = NCH;
                if (!m_run && enable) begin
                    m_run = 1'b1; m_ramp = 0; e.pwrdn = 1'b0;
                    m_tick_at = m_cyc + period(rate_div);
                end else begin
                    m_run = 1'b0; e.pwrdn = 1'b1;
                end
            end else if (tick) begin
                if (!was_empty) begin
                    nf = popped;
                end else begin
`ifdef PLB_DAC_STREAM_PATTERN_EN
                    for (int k = 0; k < NCH; k++) nf = nf | (FW'((m_ramp + k) % (1 << DW)) << (k * DW));
                    m_ramp = (m_ramp + 1) % (1 << DW);
`else
                    nf = m_frame;
`endif
                end
                m_frame = nf;
                e.data = fmt_m(ch_of(nf, 0), fmt_offset); e.chsel = '0; e.dclk = 1'b1;
                m_slot = 1;
                m_tick_at = m_cyc + period(rate_div);
            end else if (m_slot < NCH) begin
                e.data  = fmt_m(ch_of(m_frame, m_slot), fmt_offset);
                e.chsel = CHW'(m_slot);
                m_slot++;
            end
        end
        m_cyc++;
        m_out = e;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
        else n_pass++;
    endtask

    // Monitor: compares each registered output set with the oldest prediction.
    exp_t mon_e;
    initial begin
        forever begin
            @(posedge SPLB_Clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("S_Data",     32'(S_Data),     32'(mon_e.data));
                chk("S_ChSel",    32'(S_ChSel),    32'(mon_e.chsel));
                chk("S_DCLKIO",   32'(S_DCLKIO),   32'(mon_e.dclk));
                chk("S_PWRDN",    32'(S_PWRDN),    32'(mon_e.pwrdn));
                chk("wr_full",    32'(wr_full),    32'(mon_e.full));
                chk("fifo_level", 32'(fifo_level), 32'(mon_e.level));
                chk("underrun",   32'(underrun),   32'(mon_e.under));
                chk("overflow",   32'(overflow),   32'(mon_e.over));
            end
        end
    end

    task automatic step();
        model_step();
        @(negedge SPLB_Clk);
        wr_en = 1'b0; flush = 1'b0; clr_status = 1'b0; rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [DW-1:0] c1, input logic [DW-1:0] c0);
        wr_en = 1'b1; wr_data = {c1, c0}; step();
    endtask

    task automatic do_reset();
        rst = 1'b1; step();
        rst = 1'b1; step();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; enable = 1'b0; flush = 1'b0;
        rate_div = 16'd3; fmt_offset = 1'b0; clr_status = 1'b0;
        do_reset();
        // Basic frame: enable and push together, four-cycle period
        enable = 1'b1; push(10'h0AA, 10'h155);
        idle_cycles(12);
        // Fill beyond depth while idle, then clear flags and flush
        enable = 1'b0; idle_cycles(2);
        for (int i = 0; i < DEPTH + 1; i++) push(DW'($urandom), DW'($urandom));
        idle_cycles(2);
        clr_status = 1'b1; step();
        flush = 1'b1; step();
        idle_cycles(2);
        // Empty-FIFO run from reset
        do_reset();
        enable = 1'b1; idle_cycles(14);
        // Minimum period, back-to-back frames
        rate_div = 16'd0;
        for (int i = 0; i < 24; i++) begin
            wr_en = (i % 2 == 0); wr_data = FW'($urandom); step();
        end
        // Offset-binary conversion of the sign boundary
        enable = 1'b0; step();
        fmt_offset = 1'b1; push(10'h1FF, 10'h200); push(10'h000, 10'h3FF);
        enable = 1'b1; idle_cycles(10);
        fmt_offset = 1'b0;
        // Drop enable mid-frame, then reset mid-frame
        rate_div = 16'd5;
        push(10'h111, 10'h222); push(10'h333, 10'h044);
        idle_cycles(6);
        enable = 1'b0; step();
        idle_cycles(3);
        enable = 1'b1; idle_cycles(6);
        rst = 1'b1; step();
        idle_cycles(4);
        // Randomised traffic
        rate_div = 16'd2;
        for (int i = 0; i < 3000; i++) begin
            wr_en      = ($urandom_range(0, 1) == 0);
            wr_data    = FW'($urandom);
            fmt_offset = ($urandom_range(0, 9) == 0);
            flush      = ($urandom_range(0, 59) == 0);
            clr_status = ($urandom_range(0, 14) == 0);
            rst        = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 19) == 0) rate_div = DIVW'($urandom_range(0, 6));
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            step();
        end
        enable = 1'b0; idle_cycles(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
